// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions: XNOR Fibonacci tap table (XAPP052, widths 3..32).
// The pattern generator and this checker both import it so the taps cannot diverge.
package lfsr_checker_pkg;

    localparam int MAX_BITS = 32;

    // Bit t-1 set for every XAPP052 tap t; unsupported widths give no taps.
    function automatic logic [MAX_BITS-1:0] tap_mask(input int n);
        logic [MAX_BITS-1:0] m;
        case (n)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Feedback bit; all-ones is the lockup state and maps onto itself.
    function automatic logic xnor_taps(input logic [MAX_BITS-1:0] w, input int n);
        return ~(^(w & tap_mask(n)));
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Link-side word stream and status/counter bundle for the PRBS checker.
// master = word source / status consumer, slave = checker.
interface lfsr_checker_if #(
    parameter int NUM_BITS      = 32,
    parameter int ERR_CNT_WIDTH = 32
);
    logic                     i_valid;
    logic [NUM_BITS-1:0]      i_data;
    logic                     i_clear_counts;
    logic                     o_locked;
    logic                     o_err_pulse;
    logic [ERR_CNT_WIDTH-1:0] o_word_err_count;
    logic [ERR_CNT_WIDTH-1:0] o_bit_err_count;

    modport master (
        output i_valid, i_data, i_clear_counts,
        input  o_locked, o_err_pulse, o_word_err_count, o_bit_err_count
    );

    modport slave (
        input  i_valid, i_data, i_clear_counts,
        output o_locked, o_err_pulse, o_word_err_count, o_bit_err_count
    );
endinterface

// File: rtl/lfsr_popcount.sv
// Purpose: count of ones in the received-vs-predicted mismatch vector.
// Latency: combinational.
// Backpressure: none.
module lfsr_popcount #(
    parameter int NUM_BITS = 32,
    parameter int CNT_W    = $clog2(NUM_BITS + 1)
) (
    input  logic [NUM_BITS-1:0] vec,
    output logic [CNT_W-1:0]    count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            count = count + CNT_W'(vec[i]);
        end
    end
endmodule

// File: rtl/lfsr_checker.sv
// Purpose: self-seeding XNOR PRBS checker; locks, flywheels and counts word/bit errors.
// Latency: all outputs registered, one cycle after the sampled word.
// Backpressure: none; every valid word is consumed in the cycle it is presented.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int NUM_BITS      = 32,
    parameter int LOCK_COUNT    = 16,
    parameter int LOSS_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lfsr_checker_if.slave bus
);
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int MC_W  = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int LC_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
    localparam int PCW   = $clog2(NUM_BITS + 1);
    localparam int SW    = ((ERR_CNT_WIDTH > PCW) ? ERR_CNT_WIDTH : PCW) + 1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [NUM_BITS-1:0] lfsr_next(input logic [NUM_BITS-1:0] w);
        return {w[NUM_BITS-2:0], xnor_taps(MAX_BITS'(w), NUM_BITS)};
    endfunction

    state_t                   state_q, state_d;
    logic [NUM_BITS-1:0]      pred_q, pred_d;
    logic [MC_W-1:0]          match_q, match_d;
    logic [LC_W-1:0]          loss_q, loss_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] word_q, word_d;
    logic [ERR_CNT_WIDTH-1:0] bit_q, bit_d;

    logic [NUM_BITS-1:0] diff;
    logic [PCW-1:0]      pop;
    logic [SW-1:0]       bit_sum;
    logic                mismatch;
    logic                all_ones;

    assign diff     = bus.i_data ^ pred_q;
    assign mismatch = |diff;
    assign all_ones = &bus.i_data;
    assign bit_sum  = SW'(bit_q) + SW'(pop);

    lfsr_popcount #(
        .NUM_BITS (NUM_BITS),
        .CNT_W    (PCW)
    ) u_popcount (
        .vec   (diff),
        .count (pop)
    );

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        loss_d  = loss_q;
        err_d   = 1'b0;
        word_d  = word_q;
        bit_d   = bit_q;

        if (bus.i_valid) begin
            case (state_q)
                SEARCH: begin
                    if (!all_ones) begin
                        pred_d  = lfsr_next(bus.i_data);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!mismatch) begin
                        pred_d = lfsr_next(bus.i_data);
                        if (match_q == MC_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            loss_d  = '0;
                        end else begin
                            match_d = match_q + MC_W'(1);
                        end
                    end else begin
                        match_d = '0;
                        if (all_ones) begin
                            state_d = SEARCH;
                        end else begin
                            pred_d = lfsr_next(bus.i_data);
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so corrupted words never pull us off the sequence.
                    pred_d = lfsr_next(pred_q);
                    if (!mismatch) begin
                        loss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        word_d = (word_q == CNT_MAX) ? word_q : word_q + ERR_CNT_WIDTH'(1);
                        bit_d  = (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[ERR_CNT_WIDTH-1:0];
                        if (loss_q == LC_W'(LOSS_COUNT - 1)) begin
                            state_d = SEARCH;
                            loss_d  = '0;
                        end else begin
                            loss_d = loss_q + LC_W'(1);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (bus.i_clear_counts) begin
            word_d = '0;
            bit_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SEARCH;
            pred_q  <= '0;
            match_q <= '0;
            loss_q  <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            loss_q  <= loss_d;
            err_q   <= err_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
        end
    end

    assign bus.o_locked         = (state_q == LOCKED);
    assign bus.o_err_pulse      = err_q;
    assign bus.o_word_err_count = word_q;
    assign bus.o_bit_err_count  = bit_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: an 8-bit instance with 4-bit counters and a 32-bit instance.
module tb_lfsr_checker;

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [31:0] w;
        logic [31:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst32 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t  q8[$];
    exp_t  q32[$];
    string t8[$];
    string t32[$];

    always #5 clk = ~clk;

    lfsr_checker_if #(.NUM_BITS(8),  .ERR_CNT_WIDTH(4))  if8 ();
    lfsr_checker_if #(.NUM_BITS(32), .ERR_CNT_WIDTH(32)) if32 ();

    lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(16), .LOSS_COUNT(4), .ERR_CNT_WIDTH(4)) dut8 (
        .i_clk (clk),
        .i_rst (rst8),
        .bus   (if8.slave)
    );

    lfsr_checker #(.NUM_BITS(32), .LOCK_COUNT(16), .LOSS_COUNT(4), .ERR_CNT_WIDTH(32)) dut32 (
        .i_clk (clk),
        .i_rst (rst32),
        .bus   (if32.slave)
    );

    // Independent reference generators (XAPP052 taps 8,6,5,4 and 32,22,2,1).
    function automatic logic [7:0] nxt8(input logic [7:0] w);
        return {w[6:0], ~(w[7] ^ w[5] ^ w[4] ^ w[3])};
    endfunction

    function automatic logic [31:0] nxt32(input logic [31:0] w);
        return {w[30:0], ~(w[31] ^ w[21] ^ w[1] ^ w[0])};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each driven cycle's expectation is popped one edge later.
    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        if (q8.size() != 0) begin
            e = q8.pop_front();
            t = t8.pop_front();
            check({t, "8.locked"}, {31'd0, if8.o_locked}, {31'd0, e.lk});
            check({t, "8.pulse"},  {31'd0, if8.o_err_pulse}, {31'd0, e.ep});
            check({t, "8.words"},  {28'd0, if8.o_word_err_count}, e.w);
            check({t, "8.bits"},   {28'd0, if8.o_bit_err_count}, e.b);
        end
        if (q32.size() != 0) begin
            e = q32.pop_front();
            t = t32.pop_front();
            check({t, "32.locked"}, {31'd0, if32.o_locked}, {31'd0, e.lk});
            check({t, "32.pulse"},  {31'd0, if32.o_err_pulse}, {31'd0, e.ep});
            check({t, "32.words"},  if32.o_word_err_count, e.w);
            check({t, "32.bits"},   if32.o_bit_err_count, e.b);
        end
    end

    task automatic step8(input logic r, input logic v, input logic [7:0] d, input logic clr,
                         input logic el, input logic ep, input logic [31:0] ew, input logic [31:0] eb,
                         input string tag);
        @(negedge clk);
        rst8               = r;
        if8.i_valid        = v;
        if8.i_data         = d;
        if8.i_clear_counts = clr;
        q8.push_back('{lk: el, ep: ep, w: ew, b: eb});
        t8.push_back(tag);
    endtask

    task automatic step32(input logic r, input logic v, input logic [31:0] d, input logic clr,
                          input logic el, input logic ep, input logic [31:0] ew, input logic [31:0] eb,
                          input string tag);
        @(negedge clk);
        rst32               = r;
        if32.i_valid        = v;
        if32.i_data         = d;
        if32.i_clear_counts = clr;
        q32.push_back('{lk: el, ep: ep, w: ew, b: eb});
        t32.push_back(tag);
    endtask

    task automatic gap32(input logic el, input logic [31:0] ew, input logic [31:0] eb);
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) step32(1'b0, 1'b0, $urandom, 1'b0, el, 1'b0, ew, eb, "gap");
    endtask

    initial begin
        logic [7:0]  g8;
        logic [31:0] g32;
        int          sat;

        if8.i_valid = 1'b0;  if8.i_data = '0;  if8.i_clear_counts = 1'b0;
        if32.i_valid = 1'b0; if32.i_data = '0; if32.i_clear_counts = 1'b0;

        // Reset state
        step8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
        step8(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, "idle");

        // Lock: 1 seed + 16 matches
        g8 = 8'h01;
        for (int i = 0; i < 17; i++) begin
            step8(1'b0, 1'b1, g8, 1'b0, (i == 16), 1'b0, 0, 0, "lock");
            g8 = nxt8(g8);
        end
        step8(1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 0, 0, "nonvalid");

        // Single and multi-bit errors while locked
        step8(1'b0, 1'b1, g8 ^ 8'h01, 1'b0, 1'b1, 1'b1, 1, 1, "err1");  g8 = nxt8(g8);
        step8(1'b0, 1'b1, g8,         1'b0, 1'b1, 1'b0, 1, 1, "good1"); g8 = nxt8(g8);
        step8(1'b0, 1'b1, g8 ^ 8'h89, 1'b0, 1'b1, 1'b1, 2, 4, "err3b"); g8 = nxt8(g8);
        step8(1'b0, 1'b1, g8,         1'b0, 1'b1, 1'b0, 2, 4, "good2"); g8 = nxt8(g8);

        // Loss threshold: 3 bad + good keeps lock, 4 bad drops it
        step8(1'b0, 1'b1, g8, 1'b1, 1'b1, 1'b0, 0, 0, "clr"); g8 = nxt8(g8);
        for (int i = 0; i < 3; i++) begin
            step8(1'b0, 1'b1, g8 ^ 8'h01, 1'b0, 1'b1, 1'b1, i + 1, i + 1, "loss3");
            g8 = nxt8(g8);
        end
        step8(1'b0, 1'b1, g8, 1'b0, 1'b1, 1'b0, 3, 3, "recover"); g8 = nxt8(g8);
        for (int i = 0; i < 4; i++) begin
            step8(1'b0, 1'b1, g8 ^ 8'h01, 1'b0, (i != 3), 1'b1, 4 + i, 4 + i, "loss4");
            g8 = nxt8(g8);
        end
        for (int i = 0; i < 17; i++) begin
            step8(1'b0, 1'b1, g8, 1'b0, (i == 16), 1'b0, 7, 7, "relock");
            g8 = nxt8(g8);
        end

        // All-ones never seeds
        step8(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, "reset2");
        for (int i = 0; i < 10; i++) step8(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, "ones");
        g8 = 8'h01;
        for (int i = 0; i < 17; i++) begin
            step8(1'b0, 1'b1, g8, 1'b0, (i == 16), 1'b0, 0, 0, "lock_after_ones");
            g8 = nxt8(g8);
        end

        // Saturation of 4-bit counters, then clear on an error cycle
        step8(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0, "clr_idle");
        for (int k = 0; k < 20; k++) begin
            sat = (k + 1 > 15) ? 15 : k + 1;
            step8(1'b0, 1'b1, g8 ^ 8'h10, 1'b0, 1'b1, 1'b1, sat, sat, "sat_err"); g8 = nxt8(g8);
            step8(1'b0, 1'b1, g8, 1'b0, 1'b1, 1'b0, sat, sat, "sat_good");       g8 = nxt8(g8);
        end
        step8(1'b0, 1'b1, g8 ^ 8'hFF, 1'b0, 1'b1, 1'b1, 15, 15, "clamp8"); g8 = nxt8(g8);
        step8(1'b0, 1'b1, g8 ^ 8'h01, 1'b1, 1'b1, 1'b1, 0, 0, "clr_on_err"); g8 = nxt8(g8);
        step8(1'b0, 1'b1, g8, 1'b0, 1'b1, 1'b0, 0, 0, "after_clr"); g8 = nxt8(g8);
        step8(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, "end8");

        // 32-bit: random seed, gapped valid, reset while locked, relock
        g32 = $urandom;
        if (g32 == 32'hFFFF_FFFF) g32 = 32'h1;
        step32(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
        for (int i = 0; i < 17; i++) begin
            gap32(1'b0, 0, 0);
            step32(1'b0, 1'b1, g32, 1'b0, (i == 16), 1'b0, 0, 0, "lock");
            g32 = nxt32(g32);
        end
        gap32(1'b1, 0, 0);
        step32(1'b0, 1'b1, g32 ^ 32'h8000_0001, 1'b0, 1'b1, 1'b1, 1, 2, "err2b");
        g32 = nxt32(g32);
        gap32(1'b1, 1, 2);
        step32(1'b1, 1'b1, g32, 1'b0, 1'b0, 1'b0, 0, 0, "rst_locked");
        for (int i = 0; i < 17; i++) begin
            gap32(1'b0, 0, 0);
            step32(1'b0, 1'b1, g32, 1'b0, (i == 16), 1'b0, 0, 0, "relock");
            g32 = nxt32(g32);
        end
        step32(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, "end32");

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
